mem_unit: RTL and testbench

MEM_UNIT -- requirements
Module: mem_unit

---
 rtl/mem_unit.sv | 120 ++++++++++++
 tb/tb_mem_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_unit.sv
// mem_unit: fixed-latency 64-bit data memory with a single outstanding
// request. Completed loads are offered on the CDB and held until the
// arbiter grants them.
// Optional build macro: MEM_ALIGN_CHECK_EN. When it is defined, accesses
// that are not 8-byte aligned set a sticky misalign_err. Such a store does
// not write memory, and such a load returns zero.
module mem_unit #(
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mem_control,
  input  logic [63:0] mem_address,
  input  logic [63:0] mem_data,
  input  logic [3:0]  mem_tag,
  input  logic        cdb_grant,
  output logic        mem_ready,
  output logic        cdb_valid,
  output logic [3:0]  cdb_id,
  output logic [63:0] cdb_data,
  output logic        busy,
  output logic        misalign_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  is_load;
  logic                  bad_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [63:0]           wdata_q;
  logic [3:0]            tag_q;

  logic [63:0] mem [0:(1<<DEPTH_LOG2)-1];

  logic accept;
  logic done_edge;
  logic addr_bad;

  assign accept    = (state == IDLE) && ((mem_control == 2'b01) || (mem_control == 2'b00));
  assign done_edge = (state == BUSY) && (cnt == '0);
  assign busy      = (state != IDLE);

`ifdef MEM_ALIGN_CHECK_EN
  assign addr_bad = |mem_address[2:0];
`else
  assign addr_bad = 1'b0;
`endif

  // Address bits above the memory index wrap silently. The byte offset
  // only matters when alignment checking is built in.
  logic unused_addr;
  assign unused_addr = ^{mem_address[63:DEPTH_LOG2+3], mem_address[2:0]};

  // Store write on the BUSY-to-DONE edge. A reset on that same edge
  // suppresses the write, so an aborted store never lands in memory.
  always_ff @(posedge clk) begin
    if (rst_n && done_edge && !is_load && !bad_q)
      mem[idx_q] <= wdata_q;
  end

  // Request FSM: accept and latch, count down latency, then complete and hand off
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      is_load      <= 1'b0;
      bad_q        <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      tag_q        <= '0;
      mem_ready    <= 1'b0;
      cdb_valid    <= 1'b0;
      cdb_id       <= '0;
      cdb_data     <= '0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            is_load <= (mem_control == 2'b01);
            idx_q   <= mem_address[DEPTH_LOG2+2:3];
            wdata_q <= mem_data;
            tag_q   <= mem_tag;
            bad_q   <= addr_bad;
            cnt     <= 4'(LATENCY - 1);
            if (addr_bad)
              misalign_err <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state     <= DONE;
            mem_ready <= 1'b1;
            if (is_load) begin
              cdb_valid <= 1'b1;
              cdb_id    <= tag_q;
              cdb_data  <= bad_q ? '0 : mem[idx_q];
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (!is_load || cdb_grant) begin
            state     <= IDLE;
            mem_ready <= 1'b0;
            cdb_valid <= 1'b0;
            cdb_id    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit: directed, table-driven bench for mem_unit (LATENCY=3,
// DEPTH_LOG2=8), plus a second instance with LATENCY=1.
module tb_mem_unit;

  localparam int unsigned LAT = 3;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mem_control;
  logic [63:0] mem_address;
  logic [63:0] mem_data;
  logic [3:0]  mem_tag;
  logic        cdb_grant;
  logic        mem_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_id;
  logic [63:0] cdb_data;
  logic        busy;
  logic        misalign_err;

  logic [1:0]  l1_ctrl;
  logic        l1_ready;
  logic        l1_valid;
  logic [3:0]  l1_id;
  logic [63:0] l1_data;
  logic        l1_busy;
  logic        l1_mis;

  int errors = 0;
  int checks = 0;

  mem_unit #(.LATENCY(LAT), .DEPTH_LOG2(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_control(mem_control),
    .mem_address(mem_address), .mem_data(mem_data), .mem_tag(mem_tag),
    .cdb_grant(cdb_grant), .mem_ready(mem_ready), .cdb_valid(cdb_valid),
    .cdb_id(cdb_id), .cdb_data(cdb_data), .busy(busy),
    .misalign_err(misalign_err)
  );

  mem_unit #(.LATENCY(1), .DEPTH_LOG2(8)) u_l1 (
    .clk(clk), .rst_n(rst_n), .mem_control(l1_ctrl),
    .mem_address(mem_address), .mem_data(mem_data), .mem_tag(mem_tag),
    .cdb_grant(cdb_grant), .mem_ready(l1_ready), .cdb_valid(l1_valid),
    .cdb_id(l1_id), .cdb_data(l1_data), .busy(l1_busy),
    .misalign_err(l1_mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  ctrl;
    logic [63:0] addr;
    logic [63:0] data;
    logic [3:0]  tag;
    int unsigned stall;
    logic        ev;
    logic [3:0]  eid;
    logic [63:0] ed;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One complete request: accept, latency countdown, DONE with optional grant stall.
  task automatic run_op(input string nm, input logic [1:0] c, input logic [63:0] a,
                        input logic [63:0] d, input logic [3:0] t, input int unsigned stall,
                        input logic ev, input logic [3:0] eid, input logic [63:0] ed);
    mem_control = c;
    mem_address = a;
    mem_data    = d;
    mem_tag     = t;
    cdb_grant   = (stall == 0);
    @(posedge clk); #1;
    mem_control = 2'b11;
    chk({nm, ".busy_after_accept"}, busy, 1);
    for (int k = 1; k < int'(LAT); k++) begin
      @(posedge clk); #1;
      chk({nm, ".ready_early"}, mem_ready, 0);
      chk({nm, ".valid_early"}, cdb_valid, 0);
    end
    @(posedge clk); #1;
    chk({nm, ".ready"}, mem_ready, 1);
    chk({nm, ".valid"}, cdb_valid, ev);
    chk({nm, ".id"}, cdb_id, eid);
    if (ev) chk({nm, ".data"}, cdb_data, ed);
    for (int s = 0; s < int'(stall); s++) begin
      if (s == 0) begin
        mem_control = 2'b00;
        mem_address = a;
        mem_data    = ~ed;
        mem_tag     = 4'd10;
      end
      @(posedge clk); #1;
      chk({nm, ".stall_ready"}, mem_ready, 1);
      chk({nm, ".stall_valid"}, cdb_valid, 1);
      chk({nm, ".stall_id"}, cdb_id, eid);
      chk({nm, ".stall_data"}, cdb_data, ed);
      chk({nm, ".stall_busy"}, busy, 1);
    end
    mem_control = 2'b11;
    cdb_grant   = 1'b1;
    @(posedge clk); #1;
    chk({nm, ".ready_clear"}, mem_ready, 0);
    chk({nm, ".valid_clear"}, cdb_valid, 0);
    chk({nm, ".id_clear"}, cdb_id, 0);
    chk({nm, ".idle"}, busy, 0);
  endtask

  initial begin
    vecs[0]  = '{"st40",     2'b00, 64'h40,  64'hDEAD_BEEF,          4'd9,  0, 1'b0, 4'd0, 64'h0};
    vecs[1]  = '{"ld40",     2'b01, 64'h40,  64'h0,                  4'd6,  0, 1'b1, 4'd6, 64'hDEAD_BEEF};
    vecs[2]  = '{"ld40stl",  2'b01, 64'h40,  64'h0,                  4'd7,  5, 1'b1, 4'd7, 64'hDEAD_BEEF};
    vecs[3]  = '{"ld40chk",  2'b01, 64'h40,  64'h0,                  4'd8,  0, 1'b1, 4'd8, 64'hDEAD_BEEF};
    vecs[4]  = '{"st80",     2'b00, 64'h80,  64'hAAAA,               4'd10, 0, 1'b0, 4'd0, 64'h0};
    vecs[5]  = '{"ld80",     2'b01, 64'h80,  64'h0,                  4'd7,  0, 1'b1, 4'd7, 64'hAAAA};
    vecs[6]  = '{"st800",    2'b00, 64'h800, 64'h0123_4567_89AB_CDEF, 4'd9,  0, 1'b0, 4'd0, 64'h0};
    vecs[7]  = '{"ld0wrap",  2'b01, 64'h0,   64'h0,                  4'd6,  0, 1'b1, 4'd6, 64'h0123_4567_89AB_CDEF};
    vecs[8]  = '{"st48",     2'b00, 64'h48,  64'hFEDC_BA98_7654_3210, 4'd10, 0, 1'b0, 4'd0, 64'h0};
    vecs[9]  = '{"ld48",     2'b01, 64'h48,  64'h0,                  4'd8,  0, 1'b1, 4'd8, 64'hFEDC_BA98_7654_3210};
    vecs[10] = '{"ld40again",2'b01, 64'h40,  64'h0,                  4'd7,  0, 1'b1, 4'd7, 64'hDEAD_BEEF};

    rst_n       = 1'b0;
    mem_control = 2'b11;
    l1_ctrl     = 2'b11;
    mem_address = '0;
    mem_data    = '0;
    mem_tag     = '0;
    cdb_grant   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.ready", mem_ready, 0);
    chk("rst.valid", cdb_valid, 0);
    chk("rst.id", cdb_id, 0);
    chk("rst.data", cdb_data, 0);
    chk("rst.mis", misalign_err, 0);
    chk("rst.l1_mis", l1_mis, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].ctrl, vecs[i].addr, vecs[i].data, vecs[i].tag,
             vecs[i].stall, vecs[i].ev, vecs[i].eid, vecs[i].ed);

    // Reset in the second BUSY cycle aborts a store to 0x80.
    mem_control = 2'b00;
    mem_address = 64'h80;
    mem_data    = 64'h1234;
    mem_tag     = 4'd9;
    @(posedge clk); #1;
    mem_control = 2'b11;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort.busy", busy, 0);
    chk("abort.ready", mem_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("abort_ld80", 2'b01, 64'h80, 64'h0, 4'd6, 0, 1'b1, 4'd6, 64'hAAAA);

    // Reserved and none encodings are not accepted.
    mem_control = 2'b10;
    @(posedge clk); #1;
    chk("rsv10.busy", busy, 0);
    mem_control = 2'b11;
    @(posedge clk); #1;
    chk("none11.busy", busy, 0);

    // Misaligned store to 0x43.
    run_op("st43", 2'b00, 64'h43, 64'hBAD0_BAD0, 4'd9, 0, 1'b0, 4'd0, 64'h0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis.flag", misalign_err, 1);
    run_op("ld40_after_mis", 2'b01, 64'h40, 64'h0, 4'd6, 0, 1'b1, 4'd6, 64'hDEAD_BEEF);
    run_op("ld45_mis", 2'b01, 64'h45, 64'h0, 4'd7, 0, 1'b1, 4'd7, 64'h0);
    chk("mis.sticky", misalign_err, 1);
`else
    chk("mis.flag", misalign_err, 0);
    run_op("ld40_after_mis", 2'b01, 64'h40, 64'h0, 4'd6, 0, 1'b1, 4'd6, 64'hBAD0_BAD0);
`endif

    // LATENCY=1 instance: exactly one BUSY cycle.
    mem_address = 64'h18;
    mem_data    = 64'h77;
    mem_tag     = 4'd9;
    cdb_grant   = 1'b1;
    l1_ctrl     = 2'b00;
    @(posedge clk); #1;
    l1_ctrl = 2'b11;
    chk("l1st.busy", l1_busy, 1);
    chk("l1st.ready_early", l1_ready, 0);
    @(posedge clk); #1;
    chk("l1st.ready", l1_ready, 1);
    chk("l1st.valid", l1_valid, 0);
    @(posedge clk); #1;
    chk("l1st.idle", l1_busy, 0);
    chk("l1st.ready_clear", l1_ready, 0);
    mem_tag = 4'd6;
    l1_ctrl = 2'b01;
    @(posedge clk); #1;
    l1_ctrl = 2'b11;
    chk("l1ld.ready_early", l1_ready, 0);
    @(posedge clk); #1;
    chk("l1ld.ready", l1_ready, 1);
    chk("l1ld.valid", l1_valid, 1);
    chk("l1ld.id", l1_id, 6);
    chk("l1ld.data", l1_data, 64'h77);
    @(posedge clk); #1;
    chk("l1ld.idle", l1_busy, 0);
    chk("l1ld.valid_clear", l1_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
